// File: rtl/rpn_eval.sv
// Postfix (RPN) expression evaluator: client stage of the LIFO stack.
// Pushes operands, pops two entries per binary operator and pushes the result back.
module rpn_eval #(
  parameter int DATA_WIDTH       = 8,
  parameter int STACK_ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic                  tok_is_op,
  input  logic                  tok_last,
  input  logic [DATA_WIDTH-1:0] tok_data,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] stk_wr_data,
  input  logic [DATA_WIDTH-1:0] stk_rd_data,
  input  logic                  stk_full,
  input  logic                  stk_empty,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [1:0]            err_code
);

  // Opcodes live in tok_data[1:0], and the stack needs at least two entries.
  if (DATA_WIDTH < 2 || STACK_ADDR_WIDTH < 1) begin : g_param_check
    $error("rpn_eval: DATA_WIDTH must be >= 2 and STACK_ADDR_WIDTH must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE, POP_B, POP_A, EXEC, FINAL, CHECK, ERR
  } state_t;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
  localparam logic [1:0] ERR_LEFTOVER  = 2'b11;

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] a_q, b_q, res_q, alu_res;
  logic [1:0]            op_q, err_q;
  logic                  last_q;
  logic                  tok_fire;

  assign tok_ready = (state == IDLE);
  assign tok_fire  = tok_valid && tok_ready;

  always_comb begin
    alu_res = a_q + b_q;
    case (op_q)
      2'b00:   alu_res = a_q + b_q;
      2'b01:   alu_res = a_q - b_q;
      2'b10:   alu_res = a_q * b_q;
      default: alu_res = a_q & b_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (tok_fire) begin
          if (tok_is_op)     next_state = POP_B;
          else if (stk_full) next_state = ERR;
          else if (tok_last) next_state = FINAL;
          else               next_state = IDLE;
        end
      end
      POP_B:   next_state = stk_empty ? ERR  : POP_A;
      POP_A:   next_state = stk_empty ? ERR  : EXEC;
      EXEC:    next_state = last_q    ? FINAL : IDLE;
      FINAL:   next_state = stk_empty ? ERR  : CHECK;
      CHECK:   next_state = stk_empty ? IDLE : ERR;
      ERR:     next_state = stk_empty ? IDLE : ERR;
      default: next_state = IDLE;
    endcase
  end

  // Every pop state only pops a non-empty stack; ERR keeps popping until drained.
  always_comb begin
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_wr_data = '0;
    case (state)
      IDLE: begin
        if (tok_fire && !tok_is_op && !stk_full) begin
          stk_push    = 1'b1;
          stk_wr_data = tok_data;
        end
      end
      POP_B, POP_A, FINAL, ERR: stk_pop = !stk_empty;
      EXEC: begin
        stk_push    = 1'b1;
        stk_wr_data = alu_res;
      end
      default: ;
    endcase
  end

  // The final value is staged in res_q so result only changes together with done.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      op_q     <= 2'b00;
      last_q   <= 1'b0;
      err_q    <= ERR_OK;
      done     <= 1'b0;
      result   <= '0;
      err_code <= ERR_OK;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tok_fire) begin
            if (tok_is_op) begin
              op_q   <= tok_data[1:0];
              last_q <= tok_last;
            end else if (stk_full) begin
              err_q <= ERR_OVERFLOW;
            end
          end
        end
        POP_B: begin
          if (stk_empty) err_q <= ERR_UNDERFLOW;
          else           b_q   <= stk_rd_data;
        end
        POP_A: begin
          if (stk_empty) err_q <= ERR_UNDERFLOW;
          else           a_q   <= stk_rd_data;
        end
        FINAL: begin
          if (stk_empty) err_q <= ERR_UNDERFLOW;
          else           res_q <= stk_rd_data;
        end
        CHECK: begin
          if (stk_empty) begin
            done     <= 1'b1;
            result   <= res_q;
            err_code <= ERR_OK;
          end else begin
            err_q <= ERR_LEFTOVER;
          end
        end
        ERR: begin
          if (stk_empty) begin
            done     <= 1'b1;
            result   <= '0;
            err_code <= err_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
